// File: rtl/pe_row_acc_if.sv
// Handshake and weight-load bundle for pe_row_acc.
// The block sits on the slave modport; the feeder/consumer side uses master.
interface pe_row_acc_if #(
    parameter int DATA_BW   = 8,
    parameter int WEIGHT_BW = 8,
    parameter int LANES     = 8,
    parameter int PSUM_BW   = 20
) ();
    logic                            w_load;
    logic [WEIGHT_BW*LANES-1:0]      w_in;
    logic                            w_swap;
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_BW*LANES-1:0]        data_in;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [PSUM_BW-1:0]       data_out;
    logic                            sat_flag;

    modport master (
        output w_load, w_in, w_swap, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, sat_flag
    );

    modport slave (
        input  w_load, w_in, w_swap, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, sat_flag
    );
endinterface

// File: rtl/pe_row_acc.sv
// Pipelined row PE: LANES-wide signed dot product accumulated over TILES vectors.
// Define PE_ROW_ACC_SAT_EN to saturate the output reduction instead of wrapping.
module pe_row_acc #(
    parameter int DATA_BW   = 8,
    parameter int WEIGHT_BW = 8,
    parameter int LANES     = 8,
    parameter int TILES     = 4,
    parameter int PSUM_BW   = 20
) (
    input  logic         clk,
    input  logic         rst,
    pe_row_acc_if.slave  bus
);
    localparam int PROD_W = DATA_BW + WEIGHT_BW;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int ACC_W  = SUM_W + $clog2(TILES);
    localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;

    logic [WEIGHT_BW*LANES-1:0] shadow_w;
    logic [WEIGHT_BW*LANES-1:0] active_w;
    logic signed [PROD_W-1:0]   prod_next [LANES];
    logic signed [PROD_W-1:0]   prod      [LANES];
    logic signed [SUM_W-1:0]    tree_sum;
    logic signed [SUM_W-1:0]    s2_sum;
    logic signed [ACC_W-1:0]    acc;
    logic [TILE_W-1:0]          tile;
    logic                       s1_valid;
    logic                       s2_valid;
    logic                       acc_done;
    logic                       advance;
    logic                       accept;
    logic                       last_tile;
    logic signed [PSUM_BW-1:0]  reduced;

    // A held result blocks the whole pipeline, so no stage can overrun the output.
    assign advance      = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = advance;
    assign accept       = bus.in_valid && advance;
    assign last_tile    = (tile == TILE_W'(TILES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            if (bus.w_load) shadow_w <= bus.w_in;
            if (bus.w_swap) active_w <= shadow_w;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_next[i] = PROD_W'($signed(bus.data_in[i*DATA_BW +: DATA_BW]))
                         * PROD_W'($signed(active_w[i*WEIGHT_BW +: WEIGHT_BW]));
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + SUM_W'(prod[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            acc_done <= 1'b0;
            s2_sum   <= '0;
            acc      <= '0;
            tile     <= '0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                for (int i = 0; i < LANES; i++) prod[i] <= prod_next[i];
            end
            s2_valid <= s1_valid;
            if (s1_valid) s2_sum <= tree_sum;
            acc_done <= s2_valid && last_tile;
            if (s2_valid) begin
                acc  <= (tile == '0) ? ACC_W'(s2_sum) : acc + ACC_W'(s2_sum);
                tile <= last_tile ? '0 : tile + TILE_W'(1);
            end
        end
    end

`ifdef PE_ROW_ACC_SAT_EN
    localparam int EXT_W = (ACC_W > PSUM_BW) ? ACC_W : PSUM_BW;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({1'b0, {(PSUM_BW-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'($signed({1'b1, {(PSUM_BW-1){1'b0}}}));

    logic signed [EXT_W-1:0] acc_ext;
    logic                    reduced_sat;
    logic                    sat_q;

    always_comb begin
        acc_ext     = EXT_W'(acc);
        reduced     = acc_ext[PSUM_BW-1:0];
        reduced_sat = 1'b0;
        if (acc_ext > SAT_MAX) begin
            reduced     = SAT_MAX[PSUM_BW-1:0];
            reduced_sat = 1'b1;
        end else if (acc_ext < SAT_MIN) begin
            reduced     = SAT_MIN[PSUM_BW-1:0];
            reduced_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (advance && acc_done) begin
            sat_q <= reduced_sat;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    assign reduced      = PSUM_BW'(acc);
    assign bus.sat_flag = 1'b0;
`endif

    // When advancing, any valid result is being taken, so out_valid drops unless refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else if (advance) begin
            if (acc_done) begin
                bus.out_valid <= 1'b1;
                bus.data_out  <= reduced;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pe_row_acc.md
PE_ROW_ACC -- requirements
Module: pe_row_acc

Interface
REQ-001 SHALL have parameter DATA_BW, default 8, signed activation width per lane.
REQ-002 SHALL have parameter WEIGHT_BW, default 8, signed weight width per lane.
REQ-003 SHALL have parameter LANES, default 8, number of multiply lanes (≥2, power of two).
REQ-004 SHALL have parameter TILES, default 4, number of input vectors accumulated per result (≥1).
REQ-005 SHALL have parameter PSUM_BW, default 20, signed output width.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port w_load, input, 1: write w_in into the shadow weight bank.
REQ-009 SHALL have port w_in, input, WEIGHT_BW*LANES: packed signed weights, lane i at bits [i*WEIGHT_BW +: WEIGHT_BW].
REQ-010 SHALL have port w_swap, input, 1: copy the shadow bank into the active bank.
REQ-011 SHALL have port in_valid, input, 1: data_in valid.
REQ-012 SHALL have port in_ready, output, 1: block accepts data_in.
REQ-013 SHALL have port data_in, input, DATA_BW*LANES: packed signed activations, same lane packing.
REQ-014 SHALL have port out_valid, output, 1: data_out valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts data_out.
REQ-016 SHALL have port data_out, output, PSUM_BW: signed accumulated dot product.
REQ-017 SHALL have port sat_flag, output, 1: data_out was clipped (see Configuration).

Function
REQ-018 SHALL accept a vector on every edge with in_valid && in_ready.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready); this stall freezes every pipeline stage.
REQ-020 Stage 1 SHALL register the LANES signed products, each DATA_BW+WEIGHT_BW bits, using the active weights at the accept edge.
REQ-021 Stage 2 SHALL register the adder-tree sum at width DATA_BW+WEIGHT_BW+clog2(LANES), sign-extended, with no loss.
REQ-022 Stage 3 SHALL accumulate at ACC_W = stage-2 width + clog2(TILES) (min +0); on tile 0 it loads the sum, otherwise it adds it.
REQ-023 The tile counter SHALL advance 0..TILES-1 as each sum reaches stage 3 and wrap to 0.
REQ-024 When the tile TILES-1 sum completes, data_out SHALL load the reduced accumulator (REQ-033) with out_valid=1, three unstalled edges after that tile's accept edge.
REQ-025 out_valid SHALL stay high and data_out/sat_flag stable until out_valid && out_ready; it then clears unless a new result loads on the same edge.
REQ-026 Bubbles (no in_valid) SHALL advance the pipeline without changing the accumulator or tile counter.
REQ-027 w_load SHALL write w_in into the shadow bank at the edge; the active bank is unaffected.
REQ-028 w_swap SHALL copy the shadow bank to the active bank at the edge; a vector accepted on that same edge uses the old active bank.
REQ-029 With w_load and w_swap on the same edge, active SHALL get the old shadow, and shadow SHALL get w_in.
REQ-030 w_load and w_swap SHALL take effect regardless of stall.

Reset
REQ-031 rst SHALL asynchronously clear out_valid, sat_flag, data_out, the tile counter, the accumulator, all stage-valid bits, and both weight banks to 0.
REQ-032 rst asserted mid-tile SHALL discard partial accumulation; the first vector accepted after release is tile 0.

Configuration
REQ-033 Macro PE_ROW_ACC_SAT_EN defined: ACC_W→PSUM_BW reduction SHALL saturate to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1], with sat_flag=1 for a clipped result. Undefined: the reduction SHALL keep the low PSUM_BW bits (two's-complement wrap), with sat_flag tied 0.

Verification (defaults)
REQ-034 Active weights all 1, four vectors of all 1 on back-to-back edges, out_ready=1 -> out_valid one cycle, data_out=32, three edges after the 4th accept.
REQ-035 Weights and data all -128, 4 tiles -> exact sum 524288; with macro data_out=524287 and sat_flag=1; without macro data_out=-524288 and sat_flag=0.
REQ-036 out_ready=0 for 5 cycles while a result is valid and inputs are pending -> in_ready=0, data_out stable, no vector lost; the next result is correct after release.
REQ-037 Load shadow=2 and swap on the edge tile 2 is accepted, data=1 -> result 8+8+8+16=40.
REQ-038 rst pulse after 2 tiles, then 4 fresh tiles of weights 0 (reset) reloaded to 3, data 1 -> a single result of 96; no earlier result emitted.
